memory_access_unit: RTL and testbench
=====================================

# memory_access_unit

Memory-stage datapath and control for the pipelined Y86-64 core with branch prediction. It consumes the outputs of the execute→memory pipeline register (M_*) and drives a valid/ready data-memory bus. It stalls the pipeline while a memory transaction is outstanding and produces m_valM and m_stat for the memory→writeback register. It also resolves conditional-jump predictions carried in M and issues the redirect to fetch.

## Interface
Parameters:
- none; opcodes, register ids and status codes come from define.v.

Ports:
- clk_i  in  1  clock; all state updates on posedge.
- rst_i  in  1  reset. Synchronous, active-high.
- M_stat_i  in  3  status of the instruction in M.
- M_icode_i  in  4  icode in M.
- M_branch_taken_i  in  1  fetch predicted taken (jXX only).
- M_Cnd_i  in  1  actual condition outcome.
- M_valE_i  in  64  ALU result.
- M_valA_i  in  64  store data / pop address / alternate PC for jXX.
- M_dstE_i, M_dstM_i  in  4  each; passed through unchanged as m_dstE_o, m_dstM_o.
- dmem_req_o  out  1  request valid.
- dmem_we_o  out  1  1 = write.
- dmem_addr_o  out  64  byte address.
- dmem_wdata_o  out  64  store data.
- dmem_ready_i  in  1  request accepted this cycle.
- dmem_rvalid_i  in  1  response (read data or write ack) valid.
- dmem_rdata_i  in  64  read data.
- dmem_err_i  in  1  invalid address; sampled with rvalid.
- m_valM_o  out  64  loaded value.
- m_stat_o  out  3  status forwarded to W.
- m_dstE_o, m_dstM_o  out  4  each; copies of M_dstE_i, M_dstM_i.
- m_busy_o  out  1  stall request to pipeline control.
- m_mispredict_o  out  1  jXX prediction wrong.
- m_redirect_pc_o  out  64  corrected fetch PC.

## Operation
Memory ops:
- reads: MRMOVQ (addr valE), POPQ (addr valA), RET (addr valA).
- writes: RMMOVQ, PUSHQ, CALL (addr valE, data valA).
- mem_op = one of the above AND M_stat_i == SAOK. Non-SAOK and non-memory instructions never issue.

FSM with states IDLE, WAIT, DONE:
- IDLE with mem_op: dmem_req_o = 1 and m_busy_o = 1. If dmem_ready_i → WAIT; else remain in IDLE with request held.
- WAIT: m_busy_o = 1, no request. On dmem_rvalid_i, capture rdata into data_q and err into err_q, then → DONE.
- DONE: m_busy_o = 0. m_valM_o = data_q. m_stat_o = SADR if err_q, else M_stat_i. Next state IDLE; the next instruction enters M on that edge.
- IDLE without mem_op: m_busy_o = 0, m_valM_o = 0, m_stat_o = M_stat_i.

Request fields:
- While dmem_req_o is high, addr, we and wdata are driven combinationally from M_*. They stay stable because M is stalled.

Prediction resolution (combinational, independent of FSM):
- m_mispredict_o = (M_icode_i == IJXX) && (M_Cnd_i != M_branch_taken_i).
- m_redirect_pc_o = M_valA_i, which holds the non-predicted PC for jXX.

Boundary conditions:
- dmem_rvalid_i outside WAIT is ignored.
- Reset in any state → IDLE and err_q = 0. An outstanding response is dropped; the memory is reset by the same rst_i.
- Pipeline control gives M_stall priority over M_bubble while m_busy_o = 1. This block does not observe bubble.
- Write with error: m_stat_o = SADR. The write is treated as not performed.

## Timing
- Reset values: state IDLE, data_q = 0, err_q = 0. Outputs then depend only on M_*; with a bubble in M (INOP, stat 0): req 0, busy 0, valM 0, stat 0, mispredict 0.
- Zero-wait memory (ready in the request cycle, rvalid the next cycle) costs 2 busy cycles per memory op. Result appears on the 3rd cycle.
- Each extra ready-low cycle adds 1 cycle. Each extra rvalid delay adds 1 cycle.
- Exactly one request is accepted per memory instruction.
- Mispredict and redirect are valid in the same cycle the jXX sits in M. This block adds no latency.

## Structure
- define.v holds icodes, RNONE, and status codes SAOK=1, SHLT=2, SADR=3, SINS=4 (bubble = 0).
- Add state encodings MA_IDLE, MA_WAIT, MA_DONE to define.v.
- Single module. No sub-module is warranted; memory-op decode is a local function.

## Test plan
- MRMOVQ, valE=0x100, zero-wait memory, rdata=0x1122334455667788:
  - req with we=0 and addr=0x100 on cycle 0;
  - busy on cycles 0-1;
  - cycle 2: valM=0x1122334455667788, stat=SAOK, busy=0.
- PUSHQ, valE=0x1F8, valA=0xAB, ready low for 3 cycles:
  - req held stable 4 cycles with we=1, addr=0x1F8, wdata=0xAB;
  - exactly one acceptance;
  - busy deasserts 2 cycles after acceptance.
- POPQ, valA=0x2000, rvalid with err=1 → DONE cycle shows m_stat=SADR and valM=0.
- JXX, branch_taken=1, Cnd=0, valA=0x40 → mispredict=1 and redirect=0x40 the same cycle, busy=0. With Cnd=1 → mispredict=0.
- RMMOVQ with M_stat_i=SINS → no request, busy=0, m_stat=SINS.
- rst_i asserted in WAIT, then rvalid → state IDLE, no DONE cycle, data_q=0, response ignored.

Source files
------------

// File: rtl/memory_access_unit_pkg.sv
// Shared Y86-64 encodings for the memory stage: instruction codes, register ids,
// status codes and the memory-access FSM state encoding.
package memory_access_unit_pkg;

  // Instruction codes
  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  // Register id meaning "no register"
  localparam logic [3:0] RNONE = 4'hF;

  // Status codes; 0 marks a bubble
  localparam logic [2:0] SBUB = 3'd0;
  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  // Memory-access FSM states
  typedef enum logic [1:0] {
    MA_IDLE = 2'd0,
    MA_WAIT = 2'd1,
    MA_DONE = 2'd2
  } ma_state_e;

endpackage

// File: rtl/memory_access_unit.sv
// Memory stage of the pipelined Y86-64 core.
// Issues one valid/ready data-memory transaction per load/store instruction in M,
// stalls the pipeline (m_busy) until the response has been consumed, and produces
// m_valM / m_stat for the writeback register. Also resolves jXX predictions.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   M_*_i                   execute->memory pipeline register contents
//   dmem_req/we/addr/wdata  request channel (held while ready is low)
//   dmem_ready_i            request accepted this cycle
//   dmem_rvalid/rdata/err   response channel (read data or write ack)
//   m_valM_o, m_stat_o      result for W; m_dstE_o/m_dstM_o pass-through
//   m_busy_o                stall request to pipeline control
//   m_mispredict_o          jXX in M was mispredicted
//   m_redirect_pc_o         corrected fetch PC (non-predicted PC of the jXX)
module memory_access_unit
  import memory_access_unit_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [2:0]  M_stat_i,
  input  logic [3:0]  M_icode_i,
  input  logic        M_branch_taken_i,
  input  logic        M_Cnd_i,
  input  logic [63:0] M_valE_i,
  input  logic [63:0] M_valA_i,
  input  logic [3:0]  M_dstE_i,
  input  logic [3:0]  M_dstM_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [63:0] dmem_addr_o,
  output logic [63:0] dmem_wdata_o,
  input  logic        dmem_ready_i,
  input  logic        dmem_rvalid_i,
  input  logic [63:0] dmem_rdata_i,
  input  logic        dmem_err_i,
  output logic [63:0] m_valM_o,
  output logic [2:0]  m_stat_o,
  output logic [3:0]  m_dstE_o,
  output logic [3:0]  m_dstM_o,
  output logic        m_busy_o,
  output logic        m_mispredict_o,
  output logic [63:0] m_redirect_pc_o
);

  function automatic logic is_read(input logic [3:0] icode);
    return (icode == IMRMOVQ) || (icode == IPOPQ) || (icode == IRET);
  endfunction

  function automatic logic is_write(input logic [3:0] icode);
    return (icode == IRMMOVQ) || (icode == IPUSHQ) || (icode == ICALL);
  endfunction

  ma_state_e   state_q;
  logic [63:0] data_q;
  logic        err_q;

  logic        rd;
  logic        wr;
  logic        mem_op;

  always_comb begin
    rd     = is_read(M_icode_i);
    wr     = is_write(M_icode_i);
    // Faulted or bubbled instructions never touch memory
    mem_op = (rd || wr) && (M_stat_i == SAOK);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= MA_IDLE;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        MA_IDLE: begin
          if (mem_op && dmem_ready_i) begin
            state_q <= MA_WAIT;
          end
        end
        MA_WAIT: begin
          if (dmem_rvalid_i) begin
            state_q <= MA_DONE;
            // A faulting access yields no data
            data_q  <= dmem_err_i ? 64'd0 : dmem_rdata_i;
            err_q   <= dmem_err_i;
          end
        end
        MA_DONE: begin
          // M advances on this edge, so the next instruction starts in IDLE
          state_q <= MA_IDLE;
        end
        default: begin
          state_q <= MA_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    dmem_req_o   = (state_q == MA_IDLE) && mem_op;
    dmem_we_o    = wr;
    // Writes and MRMOVQ address through valE; POPQ/RET use the old %rsp in valA
    dmem_addr_o  = (wr || (M_icode_i == IMRMOVQ)) ? M_valE_i : M_valA_i;
    dmem_wdata_o = M_valA_i;

    m_busy_o = ((state_q == MA_IDLE) && mem_op) || (state_q == MA_WAIT);
    m_valM_o = (state_q == MA_DONE) ? data_q : 64'd0;
    m_stat_o = ((state_q == MA_DONE) && err_q) ? SADR : M_stat_i;

    m_dstE_o = M_dstE_i;
    m_dstM_o = M_dstM_i;

    m_mispredict_o  = (M_icode_i == IJXX) && (M_Cnd_i != M_branch_taken_i);
    m_redirect_pc_o = M_valA_i;
  end

endmodule

// File: tb/tb_memory_access_unit.sv
// Self-checking bench for memory_access_unit: directed scenarios followed by
// randomized instructions and memory latencies, checked against a cycle-count
// model of the memory stage.
module tb_memory_access_unit;
  import memory_access_unit_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [2:0]  M_stat_i;
  logic [3:0]  M_icode_i;
  logic        M_branch_taken_i;
  logic        M_Cnd_i;
  logic [63:0] M_valE_i;
  logic [63:0] M_valA_i;
  logic [3:0]  M_dstE_i;
  logic [3:0]  M_dstM_i;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [63:0] dmem_addr_o;
  logic [63:0] dmem_wdata_o;
  logic        dmem_ready_i;
  logic        dmem_rvalid_i;
  logic [63:0] dmem_rdata_i;
  logic        dmem_err_i;
  logic [63:0] m_valM_o;
  logic [2:0]  m_stat_o;
  logic [3:0]  m_dstE_o;
  logic [3:0]  m_dstM_o;
  logic        m_busy_o;
  logic        m_mispredict_o;
  logic [63:0] m_redirect_pc_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  memory_access_unit u_dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .M_stat_i         (M_stat_i),
    .M_icode_i        (M_icode_i),
    .M_branch_taken_i (M_branch_taken_i),
    .M_Cnd_i          (M_Cnd_i),
    .M_valE_i         (M_valE_i),
    .M_valA_i         (M_valA_i),
    .M_dstE_i         (M_dstE_i),
    .M_dstM_i         (M_dstM_i),
    .dmem_req_o       (dmem_req_o),
    .dmem_we_o        (dmem_we_o),
    .dmem_addr_o      (dmem_addr_o),
    .dmem_wdata_o     (dmem_wdata_o),
    .dmem_ready_i     (dmem_ready_i),
    .dmem_rvalid_i    (dmem_rvalid_i),
    .dmem_rdata_i     (dmem_rdata_i),
    .dmem_err_i       (dmem_err_i),
    .m_valM_o         (m_valM_o),
    .m_stat_o         (m_stat_o),
    .m_dstE_o         (m_dstE_o),
    .m_dstM_o         (m_dstM_o),
    .m_busy_o         (m_busy_o),
    .m_mispredict_o   (m_mispredict_o),
    .m_redirect_pc_o  (m_redirect_pc_o)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Runs one instruction through M. rdly = ready-low cycles before acceptance,
  // vdly = extra cycles between acceptance and the response.
  task automatic run_instr(input logic [3:0] icode, input logic [2:0] stat,
                           input logic [63:0] vale, input logic [63:0] vala,
                           input logic bt, input logic cnd,
                           input int rdly, input int vdly,
                           input logic err, input logic [63:0] rdata);
    logic        reads;
    logic        writes;
    logic        mem;
    logic [63:0] exp_addr;
    logic [3:0]  dste;
    logic [3:0]  dstm;
    int          ncyc;
    int          resp_k;
    int          acc;
    bit          in_wait;

    reads    = icode inside {IMRMOVQ, IPOPQ, IRET};
    writes   = icode inside {IRMMOVQ, IPUSHQ, ICALL};
    mem      = (reads || writes) && (stat == SAOK);
    exp_addr = (icode inside {IPOPQ, IRET}) ? vala : vale;
    ncyc     = mem ? rdly + vdly + 3 : 1;
    resp_k   = rdly + 1 + vdly;
    acc      = 0;
    dste     = 4'($urandom_range(0, 15));
    dstm     = ($urandom_range(0, 3) == 0) ? RNONE : 4'($urandom_range(0, 14));

    for (int k = 0; k < ncyc; k++) begin
      @(posedge clk_i);
      #1;
      M_icode_i        = icode;
      M_stat_i         = stat;
      M_valE_i         = vale;
      M_valA_i         = vala;
      M_branch_taken_i = bt;
      M_Cnd_i          = cnd;
      M_dstE_i         = dste;
      M_dstM_i         = dstm;
      in_wait          = mem && (k > rdly) && (k <= resp_k);
      if (mem && k == resp_k) begin
        dmem_ready_i  = 1'b0;
        dmem_rvalid_i = 1'b1;
        dmem_err_i    = err;
        dmem_rdata_i  = rdata;
      end else if (in_wait) begin
        dmem_ready_i  = 1'b0;
        dmem_rvalid_i = 1'b0;
        dmem_err_i    = 1'($urandom_range(0, 1));
        dmem_rdata_i  = {$urandom, $urandom};
      end else begin
        // Outside the response window the memory lines carry junk that must be ignored
        dmem_ready_i  = mem ? (k == rdly) : 1'($urandom_range(0, 1));
        dmem_rvalid_i = 1'($urandom_range(0, 1));
        dmem_err_i    = 1'($urandom_range(0, 1));
        dmem_rdata_i  = {$urandom, $urandom};
      end

      @(negedge clk_i);
      if (dmem_req_o && dmem_ready_i) acc++;
      check_eq("req", 64'(dmem_req_o), 64'(mem && k <= rdly));
      if (mem && k <= rdly) begin
        check_eq("we", 64'(dmem_we_o), 64'(writes));
        check_eq("addr", dmem_addr_o, exp_addr);
        if (writes) check_eq("wdata", dmem_wdata_o, vala);
      end
      check_eq("busy", 64'(m_busy_o), 64'(mem && k < ncyc - 1));
      if (k == ncyc - 1) begin
        check_eq("valM", m_valM_o, (mem && !err) ? rdata : 64'd0);
        check_eq("stat", 64'(m_stat_o), 64'((mem && err) ? SADR : stat));
      end
      check_eq("mispredict", 64'(m_mispredict_o), 64'((icode == IJXX) && (cnd != bt)));
      check_eq("redirect", m_redirect_pc_o, vala);
      check_eq("dstE", 64'(m_dstE_o), 64'(dste));
      check_eq("dstM", 64'(m_dstM_o), 64'(dstm));
    end
    check_eq("accepts", 64'(acc), mem ? 64'd1 : 64'd0);
  endtask

  initial begin
    rst_i            = 1'b1;
    M_stat_i         = SBUB;
    M_icode_i        = INOP;
    M_branch_taken_i = 1'b0;
    M_Cnd_i          = 1'b0;
    M_valE_i         = '0;
    M_valA_i         = '0;
    M_dstE_i         = RNONE;
    M_dstM_i         = RNONE;
    dmem_ready_i     = 1'b0;
    dmem_rvalid_i    = 1'b0;
    dmem_rdata_i     = '0;
    dmem_err_i       = 1'b0;

    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    check_eq("rst_req", 64'(dmem_req_o), 64'd0);
    check_eq("rst_busy", 64'(m_busy_o), 64'd0);
    check_eq("rst_valM", m_valM_o, 64'd0);
    check_eq("rst_stat", 64'(m_stat_o), 64'(SBUB));
    check_eq("rst_mispredict", 64'(m_mispredict_o), 64'd0);

    // Directed scenarios
    run_instr(IMRMOVQ, SAOK, 64'h100, 64'h0, 1'b0, 1'b0, 0, 0, 1'b0, 64'h1122334455667788);
    run_instr(IPUSHQ, SAOK, 64'h1F8, 64'hAB, 1'b0, 1'b0, 3, 0, 1'b0, 64'h0);
    run_instr(IPOPQ, SAOK, 64'h2008, 64'h2000, 1'b0, 1'b0, 0, 1, 1'b1, 64'h5555);
    run_instr(IJXX, SAOK, 64'h80, 64'h40, 1'b1, 1'b0, 0, 0, 1'b0, 64'h0);
    run_instr(IJXX, SAOK, 64'h80, 64'h40, 1'b1, 1'b1, 0, 0, 1'b0, 64'h0);
    run_instr(IRMMOVQ, SINS, 64'h300, 64'h77, 1'b0, 1'b0, 0, 0, 1'b0, 64'h0);
    run_instr(ICALL, SAOK, 64'h1F0, 64'h123, 1'b0, 1'b0, 1, 2, 1'b1, 64'h0);
    run_instr(IRET, SAOK, 64'h1F8, 64'h1F0, 1'b0, 1'b0, 2, 2, 1'b0, 64'hCAFE);

    // Reset while waiting for a response: the response must be dropped
    @(posedge clk_i);
    #1;
    M_icode_i     = IMRMOVQ;
    M_stat_i      = SAOK;
    M_valE_i      = 64'h300;
    dmem_ready_i  = 1'b1;
    dmem_rvalid_i = 1'b0;
    dmem_err_i    = 1'b0;
    @(negedge clk_i);
    check_eq("rstw_req", 64'(dmem_req_o), 64'd1);
    @(posedge clk_i);
    #1;
    dmem_ready_i = 1'b0;
    rst_i        = 1'b1;
    @(negedge clk_i);
    check_eq("rstw_busy_wait", 64'(m_busy_o), 64'd1);
    check_eq("rstw_noreq_wait", 64'(dmem_req_o), 64'd0);
    @(posedge clk_i);
    #1;
    rst_i         = 1'b0;
    M_icode_i     = INOP;
    M_stat_i      = SBUB;
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 64'hDEADBEEF0BADF00D;
    dmem_err_i    = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      check_eq("rstw_busy", 64'(m_busy_o), 64'd0);
      check_eq("rstw_req", 64'(dmem_req_o), 64'd0);
      check_eq("rstw_valM", m_valM_o, 64'd0);
      check_eq("rstw_stat", 64'(m_stat_o), 64'(SBUB));
      @(posedge clk_i);
      #1 dmem_rvalid_i = 1'b0;
    end

    // Randomized instruction stream
    for (int n = 0; n < 300; n++) begin
      logic [3:0] icode;
      logic [2:0] stat;
      icode = 4'($urandom_range(0, 11));
      stat  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 4)) : SAOK;
      run_instr(icode, stat, {32'd0, $urandom}, {32'd0, $urandom},
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                ($urandom_range(0, 4) == 0), {$urandom, $urandom});
    end

    // Keep a few encodings referenced so the table stays in sync with the core
    run_instr(IHALT, SHLT, 64'h0, 64'h0, 1'b0, 1'b0, 0, 0, 1'b0, 64'h0);
    run_instr(IRRMOVQ, SAOK, 64'h9, 64'h9, 1'b0, 1'b0, 0, 0, 1'b0, 64'h0);
    run_instr(IIRMOVQ, SAOK, 64'hA, 64'h0, 1'b0, 1'b0, 0, 0, 1'b0, 64'h0);
    run_instr(IOPQ, SAOK, 64'hB, 64'h1, 1'b0, 1'b0, 0, 0, 1'b0, 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
